// File: rtl/stack_rf_pkg.sv
// Shared types and constants for the stack-pointer register file.
package stack_rf_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    // Address width for a power-of-2 register count (at least one bit).
    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    typedef enum logic [1:0] {
        SP_NONE,
        SP_PUSH,
        SP_POP,
        SP_ILLEGAL
    } sp_op_e;

endpackage

// File: rtl/stack_reg_file_if.sv
// Writeback/decode-side bus of the stack register file.
interface stack_reg_file_if #(
    parameter int DATA_W = stack_rf_pkg::DEF_DATA_W,
    parameter int ADDR_W = stack_rf_pkg::addr_w(stack_rf_pkg::DEF_NUM_REGS)
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic              sp_inc;
    logic              sp_dec;
    logic              err_clr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] sp_val;
    logic              ovf;
    logic              unf;
    logic              conflict;

    modport master (
        output we, wr_addr, wr_data, ra_addr, rb_addr, sp_inc, sp_dec, err_clr,
        input  ra_data, rb_data, sp_val, ovf, unf, conflict
    );

    modport slave (
        input  we, wr_addr, wr_data, ra_addr, rb_addr, sp_inc, sp_dec, err_clr,
        output ra_data, rb_data, sp_val, ovf, unf, conflict
    );
endinterface

// File: rtl/stack_ptr_unit.sv
// Stack pointer register with bounded push/pop stepping and sticky error flags.
module stack_ptr_unit
    import stack_rf_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_LIMIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sp_inc,
    input  logic              sp_dec,
    input  logic              err_clr,
    input  logic              wr_sp,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] sp_val,
    output logic [DATA_W-1:0] sp_plus1,
    output logic              wr_sp_blocked,
    output logic              ovf,
    output logic              unf,
    output logic              conflict
);

    sp_op_e            sp_op;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] sp_nxt;
    logic              ovf_set;
    logic              unf_set;
    logic              conflict_set;

    always_comb begin
        case ({sp_inc, sp_dec})
            2'b01:   sp_op = SP_PUSH;
            2'b10:   sp_op = SP_POP;
            2'b11:   sp_op = SP_ILLEGAL;
            default: sp_op = SP_NONE;
        endcase
    end

    // Any step request (even one that ends up holding) takes priority over a direct SP write.
    always_comb begin
        sp_nxt        = sp_q;
        ovf_set       = 1'b0;
        unf_set       = 1'b0;
        conflict_set  = 1'b0;
        wr_sp_blocked = wr_sp && (sp_op != SP_NONE);
        case (sp_op)
            SP_PUSH: begin
                if (sp_q == SP_LIMIT) ovf_set = 1'b1;
                else                  sp_nxt  = sp_q - DATA_W'(1);
            end
            SP_POP: begin
                if (sp_q == SP_RESET) unf_set = 1'b1;
                else                  sp_nxt  = sp_q + DATA_W'(1);
            end
            SP_ILLEGAL: conflict_set = 1'b1;
            default: begin
                if (wr_sp) sp_nxt = wr_data;
            end
        endcase
        if (wr_sp_blocked) conflict_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q     <= SP_RESET;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            conflict <= 1'b0;
        end else begin
            sp_q     <= sp_nxt;
            ovf      <= (ovf & ~err_clr) | ovf_set;
            unf      <= (unf & ~err_clr) | unf_set;
            conflict <= (conflict & ~err_clr) | conflict_set;
        end
    end

    assign sp_val   = sp_q;
    assign sp_plus1 = sp_q + DATA_W'(1);

endmodule

// File: rtl/stack_reg_file.sv
// Parametrised register file with one stack-pointer register and two async read ports.
// Write-through forwarding on the read ports is enabled by defining STACK_REG_FILE_BYPASS_EN.
module stack_reg_file
    import stack_rf_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter int                SP_IDX   = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_LIMIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    stack_reg_file_if.slave  bus
);

    localparam int                ADDR_W  = addr_w(NUM_REGS);
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

    // The SP slot of this array is never written; reads of SP come from the pointer unit.
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_sp;
    logic              wr_sp_blocked;
    logic [DATA_W-1:0] sp_val;
    logic [DATA_W-1:0] sp_plus1;
    logic [DATA_W-1:0] ra_mux;
    logic [DATA_W-1:0] rb_mux;

    assign wr_sp = bus.we && (bus.wr_addr == SP_ADDR);

    stack_ptr_unit #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk           (clk),
        .rst           (rst),
        .sp_inc        (bus.sp_inc),
        .sp_dec        (bus.sp_dec),
        .err_clr       (bus.err_clr),
        .wr_sp         (wr_sp),
        .wr_data       (bus.wr_data),
        .sp_val        (sp_val),
        .sp_plus1      (sp_plus1),
        .wr_sp_blocked (wr_sp_blocked),
        .ovf           (bus.ovf),
        .unf           (bus.unf),
        .conflict      (bus.conflict)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bus.we && !wr_sp) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        ra_mux = (bus.ra_addr == SP_ADDR) ? sp_val : regs[bus.ra_addr];
        rb_mux = (bus.rb_addr == SP_ADDR) ? sp_val : regs[bus.rb_addr];
`ifdef STACK_REG_FILE_BYPASS_EN
        if (bus.we && !wr_sp_blocked && (bus.ra_addr == bus.wr_addr)) ra_mux = bus.wr_data;
        if (bus.we && !wr_sp_blocked && (bus.rb_addr == bus.wr_addr)) rb_mux = bus.wr_data;
`endif
        // A pop reads the slot above SP in the same cycle, ahead of any forwarding.
        if ((bus.ra_addr == SP_ADDR) && bus.sp_inc) ra_mux = sp_plus1;
    end

`ifndef STACK_REG_FILE_BYPASS_EN
    logic unused_wr_sp_blocked;
    assign unused_wr_sp_blocked = wr_sp_blocked;
`endif

    assign bus.ra_data = ra_mux;
    assign bus.rb_data = rb_mux;
    assign bus.sp_val  = sp_val;

endmodule

// File: tb/tb_stack_reg_file.sv
// Directed and randomized bench for stack_reg_file against a register-array model.
module tb_stack_reg_file;

    localparam int         NR  = 4;
    localparam logic [7:0] SPR = 8'hFF;
    localparam logic [7:0] SPL = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_reg_file_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    stack_reg_file #(.DATA_W(8), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_r [NR];
    logic       m_ovf, m_unf, m_conf;
    bit         m_valid = 1'b0;
    logic [7:0] pre_ra, pre_rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [1:0] a, input bit port_a);
        if (port_a && a == 2'(NR - 1) && bus.sp_inc) return m_r[NR-1] + 8'd1;
`ifdef STACK_REG_FILE_BYPASS_EN
        if (bus.we && bus.wr_addr == a && !(bus.wr_addr == 2'(NR - 1) && (bus.sp_inc || bus.sp_dec)))
            return bus.wr_data;
`endif
        return m_r[a];
    endfunction

    task automatic model_step();
        logic [7:0] sp;
        bit so, su, sc;
        if (rst) begin
            foreach (m_r[i]) m_r[i] = 8'h00;
            m_r[NR-1] = SPR;
            m_ovf = 1'b0; m_unf = 1'b0; m_conf = 1'b0;
            m_valid = 1'b1;
            return;
        end
        sp = m_r[NR-1]; so = 0; su = 0; sc = 0;
        if (bus.sp_inc && bus.sp_dec) sc = 1;
        else if (bus.sp_dec) begin if (sp == SPL) so = 1; else sp = sp - 8'd1; end
        else if (bus.sp_inc) begin if (sp == SPR) su = 1; else sp = sp + 8'd1; end
        if (bus.we) begin
            if (bus.wr_addr == 2'(NR - 1)) begin
                if (bus.sp_inc || bus.sp_dec) sc = 1;
                else sp = bus.wr_data;
            end else begin
                m_r[bus.wr_addr] = bus.wr_data;
            end
        end
        m_r[NR-1] = sp;
        m_ovf  = so | (m_ovf  & ~bus.err_clr);
        m_unf  = su | (m_unf  & ~bus.err_clr);
        m_conf = sc | (m_conf & ~bus.err_clr);
    endtask

    task automatic cycle(input bit r, input bit we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic [1:0] ra, input logic [1:0] rb,
                         input bit inc, input bit dec, input bit clr);
        @(negedge clk);
        rst = r; bus.we = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.ra_addr = ra; bus.rb_addr = rb;
        bus.sp_inc = inc; bus.sp_dec = dec; bus.err_clr = clr;
        #1;
        pre_ra = bus.ra_data;
        pre_rb = bus.rb_data;
        if (m_valid) begin
            chk("ra_data",  bus.ra_data,  exp_read(ra, 1'b1));
            chk("rb_data",  bus.rb_data,  exp_read(rb, 1'b0));
            chk("sp_val",   bus.sp_val,   m_r[NR-1]);
            chk("ovf",      bus.ovf,      m_ovf);
            chk("unf",      bus.unf,      m_unf);
            chk("conflict", bus.conflict, m_conf);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
        cycle(0, 0, 2'd0, 8'h00, ra, rb, 0, 0, 0);
    endtask

    initial begin
        bus.we = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.ra_addr = 0; bus.rb_addr = 0;
        bus.sp_inc = 0; bus.sp_dec = 0; bus.err_clr = 0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_sp", bus.sp_val, 8'hFF);
        chk("reset_flags", {bus.ovf, bus.unf, bus.conflict}, 3'b000);
        for (int i = 0; i < NR; i++) begin
            logic [1:0] a;
            a = 2'(i);
            idle(a, a);
            chk("reset_read", pre_ra, (i == NR - 1) ? 8'hFF : 8'h00);
        end

        cycle(0, 1, 2'd1, 8'hA5, 2'd0, 2'd1, 0, 0, 0);
`ifdef STACK_REG_FILE_BYPASS_EN
        chk("write_same_cycle", pre_rb, 8'hA5);
`else
        chk("write_same_cycle", pre_rb, 8'h00);
`endif
        idle(2'd0, 2'd1);
        chk("write_next_cycle", pre_rb, 8'hA5);

        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("three_push", bus.sp_val, 8'hFC);
        cycle(0, 0, 0, 0, 2'd3, 2'd3, 1, 0, 0);
        chk("pop_read_above", pre_ra, 8'hFD);
        chk("pop_rb_unadjusted", pre_rb, 8'hFC);
        chk("pop_sp", bus.sp_val, 8'hFD);

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("underflow_hold", bus.sp_val, 8'hFF);
        chk("underflow_flag", bus.unf, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("underflow_clear", bus.unf, 1'b0);

        cycle(0, 1, 2'd3, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("overflow_hold", bus.sp_val, 8'h00);
        chk("overflow_flag", bus.ovf, 1'b1);

        cycle(0, 1, 2'd3, 8'h80, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("dual_op_hold", bus.sp_val, 8'h80);
        chk("dual_op_conflict", bus.conflict, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("conflict_clear", bus.conflict, 1'b0);
        cycle(0, 1, 2'd3, 8'h10, 0, 0, 0, 1, 0);
        chk("write_vs_push_sp", bus.sp_val, 8'h7F);
        chk("write_vs_push_conflict", bus.conflict, 1'b1);
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("rst_sp", bus.sp_val, 8'hFF);
        chk("rst_flags", {bus.ovf, bus.unf, bus.conflict}, 3'b000);
        idle(2'd1, 2'd3);
        chk("rst_reg1", pre_ra, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] wd;
            case ($urandom_range(0, 4))
                0:       wd = 8'h00;
                1:       wd = 8'hFF;
                2:       wd = 8'h01;
                3:       wd = 8'hFE;
                default: wd = 8'($urandom);
            endcase
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 2'($urandom), wd,
                  2'($urandom), 2'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
